// File: rtl/frog_controller_if.sv
// Frog position / level-counter link: position and pulses out of the controller,
// return-home request back in.
interface frog_controller_if #(
  parameter int unsigned X_BITS = 5,
  parameter int unsigned Y_BITS = 4
);
  logic              reset_frog;
  logic [X_BITS-1:0] frog_x;
  logic [Y_BITS-1:0] frog_y;
  logic              frog_at_top;
  logic              frog_moved;

  modport master (
    input  reset_frog,
    output frog_x,
    output frog_y,
    output frog_at_top,
    output frog_moved
  );

  modport slave (
    output reset_frog,
    input  frog_x,
    input  frog_y,
    input  frog_at_top,
    input  frog_moved
  );
endinterface

// File: rtl/frog_controller.sv
// Frog position controller: debounces four direction buttons, steps the frog one cell per
// press, and signals arrival at the top row to the level counter.
module frog_controller #(
  parameter int unsigned GRID_W          = 20,
  parameter int unsigned GRID_H          = 15,
  parameter int unsigned START_X         = 10,
  parameter int unsigned START_Y         = 14,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned X_BITS          = 5,
  parameter int unsigned Y_BITS          = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_btn_up,
  input  logic               i_btn_down,
  input  logic               i_btn_left,
  input  logic               i_btn_right,
  frog_controller_if.master  bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [X_BITS-1:0] X_HOME  = X_BITS'(START_X);
  localparam logic [X_BITS-1:0] X_MAX   = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_HOME  = Y_BITS'(START_Y);
  localparam logic [Y_BITS-1:0] Y_MAX   = Y_BITS'(GRID_H - 1);
  localparam logic [Y_BITS-1:0] Y_ONE   = Y_BITS'(1);

  typedef enum logic [1:0] {StPlay, StAtTop, StWaitHome} state_e;

  // Bit order: 0 up, 1 down, 2 left, 3 right (also the step priority order).
  logic [3:0]            w_btn_raw;
  logic [3:0]            r_sync1;
  logic [3:0]            r_sync2;
  logic [3:0]            r_db;
  logic [3:0]            r_db_prev;
  logic [3:0]            r_evt;
  logic [3:0][CNT_W-1:0] r_cnt;

  assign w_btn_raw = {i_btn_right, i_btn_left, i_btn_down, i_btn_up};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      r_evt     <= '0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= w_btn_raw;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      r_evt     <= r_db & ~r_db_prev;
      for (int b = 0; b < 4; b++) begin
        if (r_sync2[b] == r_db[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == CNT_MAX) begin
          r_cnt[b] <= '0;
          r_db[b]  <= r_sync2[b];
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  state_e            r_state;
  state_e            w_state_next;
  logic [X_BITS-1:0] r_x;
  logic [X_BITS-1:0] w_x_next;
  logic [Y_BITS-1:0] r_y;
  logic [Y_BITS-1:0] w_y_next;
  logic              r_moved;
  logic              w_moved_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StPlay;
      r_x     <= X_HOME;
      r_y     <= Y_HOME;
      r_moved <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_moved <= w_moved_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_moved_next = 1'b0;
    case (r_state)
      StPlay: begin
        if (bus.reset_frog) begin
          w_x_next = X_HOME;
          w_y_next = Y_HOME;
        end else if (r_evt[0]) begin
          // The highest-priority event wins even if it is clamped; lower ones are dropped.
          if (r_y != '0) begin
            w_y_next     = r_y - 1'b1;
            w_moved_next = 1'b1;
            if (r_y == Y_ONE) w_state_next = StAtTop;
          end
        end else if (r_evt[1]) begin
          if (r_y != Y_MAX) begin
            w_y_next     = r_y + 1'b1;
            w_moved_next = 1'b1;
          end
        end else if (r_evt[2]) begin
          if (r_x != '0) begin
            w_x_next     = r_x - 1'b1;
            w_moved_next = 1'b1;
          end
        end else if (r_evt[3]) begin
          if (r_x != X_MAX) begin
            w_x_next     = r_x + 1'b1;
            w_moved_next = 1'b1;
          end
        end
      end
      StAtTop: begin
        if (bus.reset_frog) begin
          w_state_next = StPlay;
          w_x_next     = X_HOME;
          w_y_next     = Y_HOME;
        end else begin
          w_state_next = StWaitHome;
        end
      end
      StWaitHome: begin
        if (bus.reset_frog) begin
          w_state_next = StPlay;
          w_x_next     = X_HOME;
          w_y_next     = Y_HOME;
        end
      end
      default: w_state_next = StPlay;
    endcase
  end

  always_comb begin
    bus.frog_x      = r_x;
    bus.frog_y      = r_y;
    bus.frog_moved  = r_moved;
    bus.frog_at_top = (r_state == StAtTop);
  end

endmodule

// File: tb/tb_frog_controller.sv
// Randomised and directed bench for frog_controller against a cycle-level behavioural model.
module tb_frog_controller;

  localparam int W = 20;
  localparam int H = 15;
  localparam int HX = 10;
  localparam int HY = 14;
  localparam int D = 4;
  localparam int SETTLE = 14;

  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] btn;
  logic tie_rf;
  logic rf_drv;

  frog_controller_if #(.X_BITS(5), .Y_BITS(4)) bus ();

  assign bus.reset_frog = tie_rf ? bus.frog_at_top : rf_drv;

  frog_controller #(
    .GRID_W(W), .GRID_H(H), .START_X(HX), .START_Y(HY),
    .DEBOUNCE_CYCLES(D), .X_BITS(5), .Y_BITS(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_btn_up   (btn[0]),
    .i_btn_down (btn[1]),
    .i_btn_left (btn[2]),
    .i_btn_right(btn[3]),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_top = 0;
  int n_moved = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 playing, 1 arrival cycle, 2 waiting at top for return-home
  int m_x, m_y, m_mode;
  bit m_moved;
  bit [3:0] m_s1, m_s2, m_db, m_dbp, m_evt;
  int m_run [4];
  int step_dx [4] = '{0, 0, -1, 1};
  int step_dy [4] = '{-1, 1, 0, 0};

  task automatic model_reset();
    m_x = HX; m_y = HY; m_mode = 0; m_moved = 0;
    m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0; m_evt = '0;
    for (int b = 0; b < 4; b++) m_run[b] = 0;
  endtask

  task automatic model_step();
    bit rf;
    int nx, ny, dir;
    rf = tie_rf ? (m_mode == 1) : rf_drv;
    m_moved = 0;
    if (m_mode == 0) begin
      if (rf) begin
        m_x = HX; m_y = HY;
      end else if (m_evt != 0) begin
        dir = 0;
        while (!m_evt[dir]) dir++;
        nx = m_x + step_dx[dir];
        ny = m_y + step_dy[dir];
        if (nx >= 0 && nx < W && ny >= 0 && ny < H) begin
          m_x = nx; m_y = ny; m_moved = 1;
          if (ny == 0) m_mode = 1;
        end
      end
    end else begin
      if (rf) begin
        m_mode = 0; m_x = HX; m_y = HY;
      end else begin
        m_mode = 2;
      end
    end
    // Input path: 2-cycle delay, accept a level after D consecutive differing cycles,
    // event appears one cycle after the accepted rise.
    for (int b = 0; b < 4; b++) begin
      m_evt[b] = m_db[b] && !m_dbp[b];
      m_dbp[b] = m_db[b];
      if (m_s2[b] != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_db[b] = m_s2[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
      m_s2[b] = m_s1[b];
      m_s1[b] = btn[b];
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      check("x", int'(bus.frog_x), m_x);
      check("y", int'(bus.frog_y), m_y);
      check("moved", int'(bus.frog_moved), int'(m_moved));
      check("at_top", int'(bus.frog_at_top), int'(m_mode == 1));
      if (bus.frog_at_top === 1'b1) n_top++;
      if (bus.frog_moved === 1'b1) n_moved++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [3:0] mask, input int hold);
    btn = mask;
    repeat (hold) @(posedge clk);
    #1 btn = '0;
    repeat (SETTLE) @(posedge clk);
    #1;
  endtask

  task automatic rf_pulse();
    rf_drv = 1'b1;
    @(posedge clk);
    #1 rf_drv = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int top0, mv0;
  bit found;

  initial begin
    reset_n = 1'b0; btn = '0; tie_rf = 1'b0; rf_drv = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: idle after reset
    repeat (10) @(posedge clk);
    #1;
    check("t1_x", int'(bus.frog_x), 10);
    check("t1_y", int'(bus.frog_y), 14);
    check("t1_top", int'(bus.frog_at_top), 0);
    check("t1_moved", int'(bus.frog_moved), 0);

    // 2: glitch rejected, long hold gives one step
    mv0 = n_moved;
    btn = 4'b0001;
    @(posedge clk);
    #1 btn = '0;
    repeat (SETTLE) @(posedge clk);
    #1;
    check("t2_glitch_y", int'(bus.frog_y), 14);
    press(4'b0001, 20);
    check("t2_steps", n_moved - mv0, 1);
    check("t2_y", int'(bus.frog_y), 13);

    // 3: climb with reset_frog tied to frog_at_top
    rf_pulse();
    tie_rf = 1'b1;
    top0 = n_top;
    for (int i = 0; i < 13; i++) press(4'b0001, 8);
    check("t3_y_before_top", int'(bus.frog_y), 1);
    press(4'b0001, 8);
    check("t3_top_cycles", n_top - top0, 1);
    check("t3_x_home", int'(bus.frog_x), 10);
    check("t3_y_home", int'(bus.frog_y), 14);

    // 4: climb with reset_frog held low, presses ignored at top
    tie_rf = 1'b0;
    top0 = n_top;
    for (int i = 0; i < 14; i++) press(4'b0001, 8);
    check("t4_y_top", int'(bus.frog_y), 0);
    mv0 = n_moved;
    press(4'b0001, 8);
    press(4'b0010, 8);
    press(4'b0100, 8);
    check("t4_top_cycles", n_top - top0, 1);
    check("t4_no_moves", n_moved - mv0, 0);
    check("t4_y_held", int'(bus.frog_y), 0);
    rf_pulse();
    check("t4_y_home", int'(bus.frog_y), 14);

    // 5: left clamp, simultaneous up+right
    for (int i = 0; i < 10; i++) press(4'b0100, 8);
    check("t5_x0", int'(bus.frog_x), 0);
    mv0 = n_moved;
    press(4'b0100, 8);
    check("t5_clamp_x", int'(bus.frog_x), 0);
    check("t5_clamp_moved", n_moved - mv0, 0);
    press(4'b1001, 8);
    check("t5_prio_y", int'(bus.frog_y), 13);
    check("t5_prio_x", int'(bus.frog_x), 0);

    // 6: reset_n asserted during the arrival cycle
    rf_pulse();
    for (int i = 0; i < 13; i++) press(4'b0001, 8);
    check("t6_y1", int'(bus.frog_y), 1);
    btn = 4'b0001;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.frog_at_top === 1'b1) found = 1'b1;
    end
    check("t6_top_seen", int'(found), 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_top_drop", int'(bus.frog_at_top), 0);
    check("t6_x", int'(bus.frog_x), 10);
    check("t6_y", int'(bus.frog_y), 14);
    btn = '0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    press(4'b0001, 8);
    check("t6_play_after_reset", int'(bus.frog_y), 13);

    // random phase, checked per cycle by the model
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) == 0) tie_rf = ~tie_rf;
      btn = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) btn = btn | 4'b0001;
      rf_drv = ($urandom_range(0, 7) == 0);
      repeat ($urandom_range(1, 12)) @(posedge clk);
      #1 rf_drv = 1'b0;
      btn = '0;
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
